// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// The helpers turn a lane index into a bit offset into the flattened port buses.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;

  // Address width for a register count; a minimum of one bit keeps ports legal.
  function automatic int calcAw(input int nRegs);
    return (nRegs > 1) ? $clog2(nRegs) : 1;
  endfunction

  // Low bit of lane 'lane' in a bus made of equal 'laneWidth'-bit lanes.
  function automatic int laneLo(input int lane, input int laneWidth);
    return lane * laneWidth;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set when decode issues a producer
// and cleared when writeback delivers it. A fresh issue beats a same-cycle
// write because the new producer is still outstanding.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = calcAw(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rs_addr,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] rd_addr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  output logic [NRD-1:0]    rs_busy
);

  logic [NREGS-1:0] r_busy;
  logic             w_allocOk;

  // Register 0 can never gain a producer when it is hardwired to zero.
  assign w_allocOk = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

  // Writes clear their destination first, then an allocation may set it again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (we[w]) begin
          r_busy[rd_addr[laneLo(w, AW) +: AW]] <= 1'b0;
        end
      end
      if (w_allocOk) begin
        r_busy[alloc_addr] <= 1'b1;
      end
    end
  end

  // Each read port looks up the stored busy bit of its own address.
  always_comb begin
    rs_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rs_busy[i] = r_busy[rs_addr[laneLo(i, AW) +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass
// and a busy scoreboard for in-flight destinations.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = calcAw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   rd_addr,
  input  logic [NWR*XLEN-1:0] rd_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NRD-1:0]  w_busyRaw;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rs_addr    (rs_addr),
    .we         (we),
    .rd_addr    (rd_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rs_busy    (w_busyRaw)
  );

  // Storage update; later write ports overwrite earlier ones so the highest index wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && !((ZERO_REG != 0) && (rd_addr[laneLo(w, AW) +: AW] == '0))) begin
          r_regs[rd_addr[laneLo(w, AW) +: AW]] <= rd_data[laneLo(w, XLEN) +: XLEN];
        end
      end
    end
  end

  // Per-port read mux: stored value, then bypass from the winning writer, then the zero register.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int i = 0; i < NRD; i++) begin : g_read
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_busy;
      w_addr = rs_addr[laneLo(i, AW) +: AW];
      w_data = r_regs[w_addr];
      w_busy = w_busyRaw[i];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (we[w] && (rd_addr[laneLo(w, AW) +: AW] == w_addr)) begin
            w_data = rd_data[laneLo(w, XLEN) +: XLEN];
            w_busy = (alloc_en && (alloc_addr == w_addr)) ? w_busyRaw[i] : 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_data = '0;
        w_busy = 1'b0;
      end
      rs_data[laneLo(i, XLEN) +: XLEN] = w_data;
      rs_busy[i] = w_busy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on and off) share one set of
// inputs and are checked every cycle against a register-level model, with
// hand-computed literal checks at the interesting points.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rsAddr;
  logic [NWR-1:0]      weV;
  logic [NWR*AW-1:0]   rdAddr;
  logic [NWR*XLEN-1:0] rdData;
  logic                allocEn;
  logic [AW-1:0]       allocAddr;
  logic [NRD*XLEN-1:0] rsData;
  logic [NRD*XLEN-1:0] rsDataNb;
  logic [NRD-1:0]      rsBusy;
  logic [NRD-1:0]      rsBusyNb;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] modelRegs [NREGS];
  logic            modelBusy [NREGS];
  logic            modelValid = 1'b0;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk(clk), .rst(rst), .rs_addr(rsAddr), .rs_data(rsData), .rs_busy(rsBusy),
    .we(weV), .rd_addr(rdAddr), .rd_data(rdData),
    .alloc_en(allocEn), .alloc_addr(allocAddr)
  );

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)
  ) u_dutNb (
    .clk(clk), .rst(rst), .rs_addr(rsAddr), .rs_data(rsDataNb), .rs_busy(rsBusyNb),
    .we(weV), .rd_addr(rdAddr), .rd_data(rdData),
    .alloc_en(allocEn), .alloc_addr(allocAddr)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // What a read of 'a' must return this cycle, from stored state and live inputs.
  function automatic void expectRead(input logic [AW-1:0] a, input bit bypassOn,
                                     output logic [XLEN-1:0] d, output logic b);
    int winner;
    winner = -1;
    d = modelRegs[a];
    b = modelBusy[a];
    if (bypassOn && a != 0) begin
      for (int w = NWR - 1; w >= 0; w--) begin
        if (winner < 0 && weV[w] && rdAddr[w*AW +: AW] == a) winner = w;
      end
      if (winner >= 0) begin
        d = rdData[winner*XLEN +: XLEN];
        if (!(allocEn && allocAddr == a)) b = 1'b0;
      end
    end
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  // Architectural state update at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        modelRegs[r] = '0;
        modelBusy[r] = 1'b0;
      end
      modelValid = 1'b1;
    end else if (modelValid) begin
      for (int w = 0; w < NWR; w++) begin
        if (weV[w] && rdAddr[w*AW +: AW] != 0) begin
          modelRegs[rdAddr[w*AW +: AW]] = rdData[w*XLEN +: XLEN];
          modelBusy[rdAddr[w*AW +: AW]] = 1'b0;
        end
      end
      if (allocEn && allocAddr != 0) modelBusy[allocAddr] = 1'b1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [XLEN-1:0] expD;
    logic            expB;
    if (modelValid && !rst) begin
      for (int p = 0; p < NRD; p++) begin
        expectRead(rsAddr[p*AW +: AW], 1'b1, expD, expB);
        checkOutput($sformatf("model byp data p%0d", p), rsData[p*XLEN +: XLEN], expD);
        checkOutput($sformatf("model byp busy p%0d", p), XLEN'(rsBusy[p]), XLEN'(expB));
        expectRead(rsAddr[p*AW +: AW], 1'b0, expD, expB);
        checkOutput($sformatf("model nb data p%0d", p), rsDataNb[p*XLEN +: XLEN], expD);
        checkOutput($sformatf("model nb busy p%0d", p), XLEN'(rsBusyNb[p]), XLEN'(expB));
      end
    end
  end

  // Drives one cycle of inputs just after a rising edge and returns at the falling edge.
  task automatic applyStimulus(input logic r, input logic [1:0] w,
                               input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                               input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                               input logic al, input logic [AW-1:0] aa,
                               input logic [AW-1:0] s0, input logic [AW-1:0] s1);
    @(posedge clk);
    #1;
    rst       = r;
    weV       = w;
    rdAddr    = {a1, a0};
    rdData    = {d1, d0};
    allocEn   = al;
    allocAddr = aa;
    rsAddr    = {s1, s0};
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; weV = '0; rdAddr = '0; rdData = '0;
    allocEn = 1'b0; allocAddr = '0; rsAddr = '0;
    applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Test 1: random traffic, then reset with a write that must be ignored.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 2'(k % 3 + 1), AW'($urandom_range(1, 31)), {$urandom, $urandom},
                    AW'($urandom_range(1, 31)), {$urandom, $urandom},
                    1'b1, AW'($urandom_range(1, 31)),
                    AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    end
    applyStimulus(1, 2'b01, 9, 64'h99, 0, 0, 1, 10, 1, 2);
    for (int a = 0; a < NREGS; a++) begin
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, AW'(a), AW'(31 - a));
      checkOutput("reset data byp", rsData[63:0], 64'h0);
      checkOutput("reset busy byp", XLEN'(rsBusy), 64'h0);
      checkOutput("reset data nb p1", rsDataNb[127:64], 64'h0);
    end

    // Test 2: write x5, then a dropped write to x0.
    applyStimulus(0, 2'b01, 5, 64'hDEAD_BEEF, 0, 0, 0, 0, 5, 0);
    checkOutput("x5 bypass same cycle", rsData[63:0], 64'hDEAD_BEEF);
    applyStimulus(0, 2'b01, 0, 64'h1234, 0, 0, 0, 0, 5, 0);
    checkOutput("x5 nb next cycle", rsDataNb[63:0], 64'hDEAD_BEEF);
    checkOutput("x0 reads zero", rsData[127:64], 64'h0);
    checkOutput("x0 busy zero", XLEN'(rsBusy[1]), 64'h0);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5);
    checkOutput("x0 after write", rsDataNb[63:0], 64'h0);

    // Test 3: bypass versus registered visibility.
    applyStimulus(0, 2'b01, 7, 64'hA5, 0, 0, 0, 0, 7, 0);
    checkOutput("x7 bypass", rsData[63:0], 64'hA5);
    checkOutput("x7 nb old", rsDataNb[63:0], 64'h0);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0);
    checkOutput("x7 nb new", rsDataNb[63:0], 64'hA5);

    // Test 4: both write ports hit x9, port 1 wins.
    applyStimulus(0, 2'b11, 9, 64'h11, 9, 64'h22, 0, 0, 9, 0);
    checkOutput("x9 bypass winner", rsData[63:0], 64'h22);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9);
    checkOutput("x9 stored winner", rsDataNb[127:64], 64'h22);

    // Test 5: scoreboard set, clear, and alloc beating a write.
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 0);
    checkOutput("x3 busy not yet", XLEN'(rsBusyNb[0]), 64'h0);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("x3 busy set", XLEN'(rsBusyNb[0]), 64'h1);
    applyStimulus(0, 2'b01, 3, 64'h33, 0, 0, 0, 0, 3, 0);
    checkOutput("x3 byp busy cleared", XLEN'(rsBusy[0]), 64'h0);
    checkOutput("x3 nb busy still", XLEN'(rsBusyNb[0]), 64'h1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 0);
    checkOutput("x3 busy after write", XLEN'(rsBusyNb[0]), 64'h0);
    checkOutput("x3 data after write", rsDataNb[63:0], 64'h33);
    applyStimulus(0, 2'b01, 3, 64'h44, 0, 0, 1, 3, 3, 0);
    checkOutput("x3 byp busy alloc wins", XLEN'(rsBusy[0]), 64'h1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 0, 3, 0);
    checkOutput("x3 busy kept", XLEN'(rsBusyNb[0]), 64'h1);
    checkOutput("x3 data updated", rsDataNb[63:0], 64'h44);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0 alloc ignored", XLEN'(rsBusyNb[0]), 64'h0);

    // Test 6: reset lands on the same edge as alloc and write.
    applyStimulus(0, 2'b01, 6, 64'h60, 0, 0, 1, 4, 4, 6);
    applyStimulus(1, 2'b01, 6, 64'h66, 0, 0, 1, 6, 4, 6);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 6);
    checkOutput("x4 busy after rst", XLEN'(rsBusyNb[0]), 64'h0);
    checkOutput("x6 busy after rst", XLEN'(rsBusyNb[1]), 64'h0);
    checkOutput("x6 data after rst", rsDataNb[127:64], 64'h0);

    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
